// File: rtl/uart_tx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_buffer
// Brief    : Byte FIFO plus launch controller feeding a UART transmitter FSM.
//            Bytes are popped one at a time into a held tx_data register and
//            offered with a level-held data-valid until the transmitter's busy
//            flag shows the frame has started and then finished.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     tx_busy,
    output logic                     tx_data_valid,
    output logic [DATA_WIDTH-1:0]    tx_data
);

    localparam int               c_AW       = $clog2(DEPTH);
    localparam logic [c_AW:0]    c_CNT_FULL = (c_AW+1)'(DEPTH);
    localparam logic [c_AW:0]    c_CNT_ONE  = (c_AW+1)'(1);
    localparam logic [c_AW-1:0]  c_PTR_ONE  = c_AW'(1);

    // Launch FSM encoding
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_SEND = 2'd2;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]       r_wr_ptr;
    logic [c_AW-1:0]       r_rd_ptr;
    logic [c_AW:0]         r_count;
    logic                  r_overflow;
    logic [1:0]            r_state;
    logic [DATA_WIDTH-1:0] r_tx_data;

    logic w_full;
    logic w_empty;
    logic w_wr_accept;
    logic w_pop;

    assign w_full      = (r_count == c_CNT_FULL);
    assign w_empty     = (r_count == '0);
    assign w_wr_accept = wr_en && !w_full;
    // Pops only come from IDLE, so a byte already in tx_data is never replaced mid-frame
    assign w_pop       = (r_state == c_IDLE) && !w_empty && !tx_busy;

    // Storage array; stale entries after reset are unreachable once the pointers clear
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and the dropped-write pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= wr_en && w_full;
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_wr_accept, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Launch FSM and the held output byte
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_tx_data <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_pop) begin
                        r_tx_data <= r_mem[r_rd_ptr];
                        r_state   <= c_REQ;
                    end
                end
                c_REQ: begin
                    // Held until the transmitter acknowledges with busy; no timeout
                    if (tx_busy) begin
                        r_state <= c_SEND;
                    end
                end
                c_SEND: begin
                    if (!tx_busy) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign full          = w_full;
    assign empty         = w_empty;
    assign count         = r_count;
    assign overflow      = r_overflow;
    // Decoded from registered state only, so the request is glitch-free
    assign tx_data_valid = (r_state == c_REQ);
    assign tx_data       = r_tx_data;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_buffer
// Brief    : Self-checking bench for uart_tx_buffer. A queue-based reference
//            model predicts occupancy and launched bytes; a scoreboard checks
//            each launch in order; a simple transmitter emulation drives busy.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_buffer;

    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic                    clk;
    logic                    reset;
    logic                    wr_en;
    logic [DW-1:0]           wr_data;
    logic                    full;
    logic                    empty;
    logic [$clog2(DEPTH):0]  count;
    logic                    overflow;
    logic                    tx_busy;
    logic                    tx_data_valid;
    logic [DW-1:0]           tx_data;

    uart_tx_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .full          (full),
        .empty         (empty),
        .count         (count),
        .overflow      (overflow),
        .tx_busy       (tx_busy),
        .tx_data_valid (tx_data_valid),
        .tx_data       (tx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 0: transmitter emulation owns tx_busy, 1/2: driver owns tx_busy
    int mode = 2;
    bit chk_en = 0;

    // Reference model state
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    bit            m_req  = 0;
    bit            m_send = 0;
    bit            m_ovf  = 0;
    logic [DW-1:0] m_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, launcher as request/in-frame flags
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                fifo_q.delete();
                exp_q.delete();
                m_req  = 0;
                m_send = 0;
                m_ovf  = 0;
                m_data = '0;
            end else begin
                bit f;
                bit pop;
                f     = (fifo_q.size() == DEPTH);
                pop   = !m_req && !m_send && (fifo_q.size() != 0) && !tx_busy;
                m_ovf = wr_en && f;
                if (pop) begin
                    m_data = fifo_q.pop_front();
                    exp_q.push_back(m_data);
                end
                if (wr_en && !f) fifo_q.push_back(wr_data);
                if (m_req) begin
                    if (tx_busy) begin
                        m_req  = 0;
                        m_send = 1;
                    end
                end else if (m_send) begin
                    if (!tx_busy) m_send = 0;
                end else if (pop) begin
                    m_req = 1;
                end
            end
        end
    end

    // Per-cycle comparison of the status outputs against the model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("count",    32'(count),         32'(fifo_q.size()));
                chk("full",     32'(full),          32'(fifo_q.size() == DEPTH));
                chk("empty",    32'(empty),         32'(fifo_q.size() == 0));
                chk("overflow", 32'(overflow),      32'(m_ovf));
                chk("valid",    32'(tx_data_valid), 32'(m_req));
                chk("tx_data",  32'(tx_data),       32'(m_data));
            end
        end
    end

    // Scoreboard monitor: each new request must carry the next expected byte
    initial begin
        bit prev_v = 0;
        forever begin
            @(negedge clk);
            if (chk_en && tx_data_valid === 1'b1 && !prev_v) begin
                if (exp_q.size() == 0) begin
                    chk("launch_unexpected", 32'(tx_data), 32'hFFFF_FFFF);
                end else begin
                    chk("launch_byte", 32'(tx_data), 32'(exp_q.pop_front()));
                end
            end
            prev_v = (tx_data_valid === 1'b1);
        end
    end

    // Transmitter emulation: busy rises two cycles into the request, random frame length,
    // then one stop cycle in which the request is ignored
    initial begin
        int xs = 0;
        int cnt = 0;
        bit hold_ok = 0;
        logic [DW-1:0] cap = '0;
        forever begin
            @(negedge clk);
            if (reset) hold_ok = 0;
            if (mode != 0) begin
                xs = 0;
            end else begin
                case (xs)
                    0: if (tx_data_valid === 1'b1) xs = 1;
                    1: begin
                        tx_busy = 1'b1;
                        cap     = tx_data;
                        hold_ok = 1;
                        cnt     = $urandom_range(3, 12);
                        xs      = 2;
                    end
                    2: begin
                        if (hold_ok && chk_en) chk("frame_hold", 32'(tx_data), 32'(cap));
                        cnt--;
                        if (cnt == 0) begin
                            tx_busy = 1'b0;
                            xs      = 3;
                        end
                    end
                    default: xs = 0;
                endcase
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        wr_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic write_burst(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = base + DW'(i);
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Directed scenarios followed by randomized traffic
    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;
        tx_busy = 1'b0;
        @(posedge clk);
        #1 chk_en = 1;
        @(negedge clk);
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_valid", 32'(tx_data_valid), 0);
        reset = 1'b0;

        // Single byte with busy held low
        mode = 2; tx_busy = 1'b0;
        @(negedge clk); wr_en = 1'b1; wr_data = 8'hA5;
        @(negedge clk); wr_en = 1'b0;
        chk("single_not_yet", 32'(tx_data_valid), 0);
        @(negedge clk);
        chk("single_valid", 32'(tx_data_valid), 1);
        chk("single_data", 32'(tx_data), 32'h A5);
        tx_busy = 1'b1;
        @(negedge clk);
        chk("single_drop", 32'(tx_data_valid), 0);
        chk("single_empty", 32'(empty), 1);
        tx_busy = 1'b0;
        repeat (3) @(negedge clk);

        // Back-to-back frames with transmitter emulation
        do_reset();
        mode = 0;
        @(negedge clk); wr_en = 1'b1; wr_data = 8'h3C;
        @(negedge clk); wr_data = 8'hC3;
        @(negedge clk); wr_en = 1'b0;
        repeat (60) @(negedge clk);
        chk("b2b_drained", 32'(empty), 1);

        // Overflow with busy forced high
        mode = 1; tx_busy = 1'b1;
        repeat (2) @(negedge clk);
        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 8) chk("ovf_full8", 32'(full), 1);
            wr_en = 1'b1; wr_data = DW'(8'h10 + i);
        end
        @(negedge clk); wr_en = 1'b0;
        chk("ovf_pulse", 32'(overflow), 1);
        chk("ovf_count", 32'(count), DEPTH);
        @(negedge clk);
        chk("ovf_pulse_end", 32'(overflow), 0);

        // Simultaneous write and pop at count 1
        do_reset();
        write_burst(1, 8'h55);
        @(negedge clk); wr_en = 1'b1; wr_data = 8'h66; tx_busy = 1'b0;
        @(negedge clk); wr_en = 1'b0; tx_busy = 1'b1;
        chk("sim_count1", 32'(count), 1);
        chk("sim_launch", 32'(tx_data), 32'h55);

        // Simultaneous pop with write to full FIFO: write dropped
        do_reset();
        write_burst(DEPTH, 8'h70);
        @(negedge clk); wr_en = 1'b1; wr_data = 8'hEE; tx_busy = 1'b0;
        @(negedge clk); wr_en = 1'b0; tx_busy = 1'b1;
        chk("simf_ovf", 32'(overflow), 1);
        chk("simf_count", 32'(count), DEPTH - 1);

        // Stalled transmitter: request held, no further pops
        do_reset();
        mode = 2; tx_busy = 1'b0;
        write_burst(2, 8'h91);
        repeat (50) @(negedge clk);
        chk("stall_valid", 32'(tx_data_valid), 1);
        chk("stall_data", 32'(tx_data), 32'h91);
        chk("stall_count", 32'(count), 1);

        // Reset mid-frame while in SEND with 3 bytes queued
        do_reset();
        mode = 0; tx_busy = 1'b0;
        write_burst(4, 8'hB0);
        begin
            int t = 0;
            while (!(tx_busy && !tx_data_valid) && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (t >= 100) chk("send_timeout", 32'(t), 0);
        end
        chk("midframe_count", 32'(count), 3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_count", 32'(count), 0);
        chk("midrst_data", 32'(tx_data), 0);
        repeat (40) @(negedge clk);
        chk("midrst_idle", 32'(tx_data_valid), 0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            wr_en   = ($urandom_range(0, 9) < 3);
            wr_data = DW'($urandom);
            reset   = ($urandom_range(0, 599) == 0);
        end
        @(negedge clk);
        wr_en = 1'b0; reset = 1'b0;
        repeat (200) @(negedge clk);
        chk("final_empty", 32'(empty), 1);
        chk("final_sb", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
